// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad matrix scanner.
// Column drive is one-hot-low: the single low bit selects the scanned column.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_e;

  // Row-sample classification: MULTI is ambiguous and never yields a key.
  typedef enum logic [1:0] {
    ROW_NONE   = 2'd0,
    ROW_SINGLE = 2'd1,
    ROW_MULTI  = 2'd2
  } row_class_e;

  localparam int KEY_CODE_W = 4;
  localparam int MATRIX_N   = 4;

  localparam logic [3:0] COL0      = 4'b1110;
  localparam logic [3:0] COL1      = 4'b1101;
  localparam logic [3:0] COL2      = 4'b1011;
  localparam logic [3:0] COL3      = 4'b0111;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Column index to one-hot-low drive pattern.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] drive;
    drive = COL0;
    case (idx)
      2'd0: drive = COL0;
      2'd1: drive = COL1;
      2'd2: drive = COL2;
      2'd3: drive = COL3;
      default: drive = COL0;
    endcase
    return drive;
  endfunction

  // Count the low (pressed) row lines in a synchronized sample.
  function automatic logic [2:0] count_low(input logic [3:0] rows);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < MATRIX_N; i++) begin
      n = n + {2'b00, ~rows[i]};
    end
    return n;
  endfunction

  // Decide whether a sample shows no key, exactly one row, or several rows.
  function automatic row_class_e classify_rows(input logic [3:0] rows);
    row_class_e cls;
    logic [2:0] n;
    n = count_low(rows);
    if (n == 3'd0) begin
      cls = ROW_NONE;
    end else if (n == 3'd1) begin
      cls = ROW_SINGLE;
    end else begin
      cls = ROW_MULTI;
    end
    return cls;
  endfunction

  // Index of the lowest-numbered low row; only meaningful for ROW_SINGLE.
  function automatic logic [1:0] low_row_index(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = MATRIX_N - 1; i >= 0; i--) begin
      if (!rows[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous row sense lines.
// Resets to all-high so the scanner sees "no key" until real samples arrive.
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] rs
);

  logic [3:0] meta_q;
  logic [3:0] meta_d;
  logic [3:0] sync_q;
  logic [3:0] sync_d;

  // Next-state for the two synchronizer stages.
  always_comb begin
    meta_d = row_n;
    sync_d = meta_q;
  end

  // Synchronizer stages, reset to the idle (unpressed) level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= ROWS_IDLE;
      sync_q <= ROWS_IDLE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign rs = sync_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad matrix scanner: drives one column low at a time, samples the
// synchronized rows once per dwell period, debounces press and release, and
// reports the accepted key as {row, col} with a one-cycle valid strobe.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            row_n,
  output logic [3:0]            col_n,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DBC_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [DBC_W-1:0] DBC_TARGET = DBC_W'(DEBOUNCE_SCANS);
  localparam logic [DBC_W-1:0] DBC_ONE    = DBC_W'(1);

  logic [3:0]            rs;
  row_class_e            row_class;
  logic [1:0]            row_idx;
  logic                  sample;

  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [1:0]            col_idx_q,   col_idx_d;
  logic [3:0]            col_n_q,     col_n_d;
  scan_state_e           state_q,     state_d;
  logic [KEY_CODE_W-1:0] cand_q,      cand_d;
  logic [DBC_W-1:0]      dbc_q,       dbc_d;
  logic [DBC_W-1:0]      rel_q,       rel_d;
  logic [KEY_CODE_W-1:0] key_code_q,  key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  key_held_q,  key_held_d;

  keypad_row_sync u_row_sync (
    .clk   (clk),
    .rst   (rst),
    .row_n (row_n),
    .rs    (rs)
  );

  // Classify the synchronized rows; only consulted on sample instants.
  always_comb begin
    row_class = classify_rows(rs);
    row_idx   = low_row_index(rs);
  end

  // Dwell counter: one column is driven for SCAN_DIV cycles, sampled on the last.
  always_comb begin
    sample = (cnt_q == CNT_LAST);
    cnt_d  = sample ? '0 : cnt_q + CNT_W'(1);
  end

  // Scan/debounce/hold decisions, all taken on sample instants.
  always_comb begin
    logic advance;
    state_d     = state_q;
    cand_d      = cand_q;
    dbc_d       = dbc_q;
    rel_d       = rel_q;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    key_valid_d = 1'b0;
    advance     = 1'b0;

    if (sample) begin
      case (state_q)
        SCAN: begin
          if (row_class == ROW_SINGLE) begin
            cand_d = {row_idx, col_idx_q};
            if (DEBOUNCE_SCANS == 1) begin
              key_code_d  = {row_idx, col_idx_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              rel_d       = '0;
              dbc_d       = '0;
              state_d     = HELD;
            end else begin
              dbc_d   = DBC_ONE;
              state_d = DEBOUNCE;
            end
          end else begin
            advance = 1'b1;
          end
        end

        DEBOUNCE: begin
          if (row_class == ROW_SINGLE && row_idx == cand_q[3:2]) begin
            if (dbc_q + DBC_ONE == DBC_TARGET) begin
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              rel_d       = '0;
              dbc_d       = '0;
              state_d     = HELD;
            end else begin
              dbc_d = dbc_q + DBC_ONE;
            end
          end else begin
            dbc_d   = '0;
            state_d = SCAN;
            advance = 1'b1;
          end
        end

        HELD: begin
          if (row_class == ROW_NONE) begin
            if (rel_q + DBC_ONE == DBC_TARGET) begin
              rel_d      = '0;
              key_held_d = 1'b0;
              state_d    = SCAN;
              advance    = 1'b1;
            end else begin
              rel_d = rel_q + DBC_ONE;
            end
          end else begin
            rel_d = '0;
          end
        end

        default: begin
          state_d = SCAN;
          dbc_d   = '0;
          rel_d   = '0;
        end
      endcase
    end

    col_idx_d = col_idx_q + {1'b0, advance};
    col_n_d   = col_drive(col_idx_d);
  end

  // All scanner state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      col_idx_q   <= 2'd0;
      col_n_q     <= COL0;
      state_q     <= SCAN;
      cand_q      <= '0;
      dbc_q       <= '0;
      rel_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      col_idx_q   <= col_idx_d;
      col_n_q     <= col_n_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      dbc_q       <= dbc_d;
      rel_q       <= rel_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Testbench for keypad_matrix_scanner with a modelled 4x4 key matrix.
// Expected key codes are queued by the stimulus; a monitor pops one per
// key_valid pulse. Direct checks cover reset, column stepping and timing.
module tb_keypad_matrix_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed = 16'h0000;
  logic [3:0]  expQ[$];
  logic [3:0]  monExp;
  logic [3:0]  colTable [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int          total = 0;
  int          bad   = 0;

  keypad_matrix_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Matrix model: a row reads low when a pressed key sits in a driven column.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_n[c]) begin
          row_n[r] = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int r, input int c, input logic down);
    pressed[r*4+c] = down;
  endtask

  // Wait (bounded) for key_held to reach a level; reports cycles waited.
  task automatic waitHeld(input logic level, input int budget, input string name, output int cycles);
    cycles = 0;
    while (key_held !== level && cycles < budget) begin
      tick();
      cycles++;
    end
    checkOutput(name, {31'b0, key_held}, {31'b0, level});
  endtask

  // Wait (bounded) for the first cycle a given column becomes driven.
  task automatic waitColEntry(input logic [3:0] target, input string name);
    int n;
    n = 0;
    while (col_n == target && n < 40) begin
      tick();
      n++;
    end
    while (col_n != target && n < 40) begin
      tick();
      n++;
    end
    checkOutput(name, {28'b0, col_n}, {28'b0, target});
  endtask

  // Scoreboard monitor: every key_valid pulse must match a queued key code.
  always @(negedge clk) begin
    if (rst && key_valid) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_key_valid: got code %0h, required no pulse", key_code);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("key_code_on_valid", {28'b0, key_code}, {28'b0, monExp});
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, required completion before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int changes;
    logic [3:0] prevCol;

    rst = 1'b0;
    repeat (3) tick();
    checkOutput("reset_col_n", {28'b0, col_n}, 32'h0000000e);
    checkOutput("reset_key_held", {31'b0, key_held}, 32'h0);

    // Run into column 1, then assert reset asynchronously mid-cycle.
    rst = 1'b1;
    repeat (6) tick();
    checkOutput("pre_reset_col1", {28'b0, col_n}, 32'h0000000d);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset_col_n", {28'b0, col_n}, 32'h0000000e);
    checkOutput("async_reset_key_code", {28'b0, key_code}, 32'h0);
    checkOutput("async_reset_key_valid", {31'b0, key_valid}, 32'h0);
    checkOutput("async_reset_key_held", {31'b0, key_held}, 32'h0);
    tick();
    tick();
    rst = 1'b1;

    // Idle scan: column advances every SCAN_DIV cycles starting from column 0.
    for (int k = 1; k <= 16; k++) begin
      tick();
      checkOutput($sformatf("col_step_%0d", k), {28'b0, col_n}, {28'b0, colTable[(k/4)%4]});
    end

    // Clean press of (2,1) at the start of a column-1 dwell.
    waitColEntry(4'b1101, "enter_col1");
    applyStimulus(2, 1, 1'b1);
    expQ.push_back(4'b1001);
    repeat (40) tick();
    checkOutput("press_key_held", {31'b0, key_held}, 32'h1);
    checkOutput("press_col_frozen", {28'b0, col_n}, 32'h0000000d);
    checkOutput("press_key_code", {28'b0, key_code}, 32'h9);

    // Release: third consecutive clean sample drops key_held.
    applyStimulus(2, 1, 1'b0);
    waitHeld(1'b0, 30, "release_held_fall", n);
    checkOutput("release_latency", n, 12);
    checkOutput("release_key_code_kept", {28'b0, key_code}, 32'h9);
    checkOutput("release_col_resume", {28'b0, col_n}, 32'h0000000b);

    // Bounce on (0,3): only two matching samples, then gone.
    waitColEntry(4'b0111, "enter_col3");
    applyStimulus(0, 3, 1'b1);
    repeat (6) tick();
    applyStimulus(0, 3, 1'b0);
    n = 0;
    while (col_n == 4'b0111 && n < 30) begin
      tick();
      n++;
    end
    checkOutput("bounce_resume_col0", {28'b0, col_n}, 32'h0000000e);
    checkOutput("bounce_key_held", {31'b0, key_held}, 32'h0);

    // Two keys in column 2: ambiguous, scanning must keep rotating.
    applyStimulus(0, 2, 1'b1);
    applyStimulus(3, 2, 1'b1);
    prevCol = col_n;
    changes = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (col_n != prevCol) begin
        changes++;
      end
      prevCol = col_n;
    end
    checkOutput("multi_col_changes", changes, 10);
    checkOutput("multi_key_held", {31'b0, key_held}, 32'h0);

    // Drop (3,2): (0,2) alone is now a clean single press.
    applyStimulus(3, 2, 1'b0);
    expQ.push_back(4'b0010);
    waitHeld(1'b1, 40, "multi_resolve_held", n);
    applyStimulus(0, 2, 1'b0);
    waitHeld(1'b0, 40, "multi_release_held", n);

    // Reset while (1,0) is held; the key is re-accepted afterwards.
    applyStimulus(1, 0, 1'b1);
    expQ.push_back(4'b0100);
    waitHeld(1'b1, 60, "held_10_rise", n);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checkOutput("midheld_reset_key_held", {31'b0, key_held}, 32'h0);
    checkOutput("midheld_reset_col_n", {28'b0, col_n}, 32'h0000000e);
    checkOutput("midheld_reset_key_code", {28'b0, key_code}, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    expQ.push_back(4'b0100);
    waitHeld(1'b1, 40, "reaccept_held", n);
    checkOutput("reaccept_latency", n, 12);
    applyStimulus(1, 0, 1'b0);
    waitHeld(1'b0, 40, "reaccept_release", n);

    repeat (10) tick();
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
